// File: rtl/ofs_fim_axis_pkt_tx.sv
// ofs_fim_axis_pkt_tx
//   AXI-Stream packet source. Takes one command at a time (length, seed,
//   tid, tdest) and emits the packet on a fully registered AXIS master port.
//   The payload is an incrementing 32-bit word pattern, so a matching checker
//   can regenerate it from the seed alone.
//
//   Optional feature macro: OFS_FIM_AXIS_PKT_TX_SOP_EN
//     defined     -> m_tuser[0] marks beat 0 of each packet (start of packet)
//     not defined -> m_tuser is tied to zero
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   command handshake; cmd_len (bytes), cmd_seed (first
//                     payload word), cmd_tid, cmd_tdest captured on accept
//   cmd_err           one-cycle pulse after a zero-length command is accepted
//   m_t*              AXIS master (valid/ready/data/keep/last/id/dest/user)
//   pkt_cnt           completed packets, wraps modulo 2^32
module ofs_fim_axis_pkt_tx #(
  parameter int TDATA_WIDTH = 512,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int LEN_WIDTH   = 16,
  parameter int TID_WIDTH   = 8,
  parameter int TDEST_WIDTH = 8,
  parameter int TUSER_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [LEN_WIDTH-1:0]   cmd_len,
  input  logic [31:0]            cmd_seed,
  input  logic [TID_WIDTH-1:0]   cmd_tid,
  input  logic [TDEST_WIDTH-1:0] cmd_tdest,
  output logic                   cmd_err,
  input  logic                   m_tready,
  output logic                   m_tvalid,
  output logic [TDATA_WIDTH-1:0] m_tdata,
  output logic [TKEEP_WIDTH-1:0] m_tkeep,
  output logic                   m_tlast,
  output logic [TID_WIDTH-1:0]   m_tid,
  output logic [TDEST_WIDTH-1:0] m_tdest,
  output logic [TUSER_WIDTH-1:0] m_tuser,
  output logic [31:0]            pkt_cnt
);

  localparam int K  = TKEEP_WIDTH;
  localparam int NW = TDATA_WIDTH / 32;

  typedef enum logic {IDLE, SEND} state_t;

  state_t r_state, w_state_nxt;
  logic   w_accept, w_first, w_load, w_done;

  // command decode; 32-bit math so len + K-1 cannot overflow at max length
  logic [31:0]          w_beats;
  logic [LEN_WIDTH-1:0] w_cmd_last_idx, w_cmd_rem;

  // per-packet context
  logic [LEN_WIDTH-1:0] r_beat, r_last_idx, r_rem;
  logic [31:0]          r_base;

  // next beat to place into the output flops
  logic [31:0]            w_nxt_base;
  logic [LEN_WIDTH-1:0]   w_nxt_beat, w_nxt_rem;
  logic                   w_nxt_last;
  logic [TKEEP_WIDTH-1:0] w_nxt_keep;
  logic [TDATA_WIDTH-1:0] w_nxt_data;

  // output flops
  logic                   r_cmd_ready, r_cmd_err, r_tvalid, r_tlast;
  logic [TDATA_WIDTH-1:0] r_tdata;
  logic [TKEEP_WIDTH-1:0] r_tkeep;
  logic [TID_WIDTH-1:0]   r_tid;
  logic [TDEST_WIDTH-1:0] r_tdest;
  logic [31:0]            r_pkt_cnt;

  assign w_beats        = (32'(cmd_len) + 32'(K - 1)) / 32'(K);
  assign w_cmd_last_idx = LEN_WIDTH'(w_beats - 32'd1);
  assign w_cmd_rem      = LEN_WIDTH'(32'(cmd_len) % 32'(K));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_first     = 1'b0;
    w_load      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_accept = 1'b1;
          if (cmd_len != '0) begin
            w_first     = 1'b1;
            w_load      = 1'b1;   // m_tvalid is low in IDLE, so the stage is free
            w_state_nxt = SEND;
          end
        end
      end
      SEND: begin
        if (r_tvalid && m_tready && r_tlast) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (m_tready || !r_tvalid) begin
          w_load = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_nxt_base = w_first ? cmd_seed : r_base + 32'(NW);
  assign w_nxt_beat = w_first ? '0 : r_beat + LEN_WIDTH'(1);
  assign w_nxt_last = w_first ? (w_cmd_last_idx == '0) : (w_nxt_beat == r_last_idx);
  assign w_nxt_rem  = w_first ? w_cmd_rem : r_rem;

  // byte enables: partial only on the last beat with a non-zero remainder
  for (genvar i = 0; i < K; i++) begin : g_keep
    assign w_nxt_keep[i] = !w_nxt_last || (w_nxt_rem == '0) || (i < int'(w_nxt_rem));
  end

  // lane w carries base + w; disabled bytes are forced to zero
  for (genvar w = 0; w < NW; w++) begin : g_lane
    logic [31:0] w_word;
    assign w_word = w_nxt_base + 32'(w);
    for (genvar b = 0; b < 4; b++) begin : g_byte
      assign w_nxt_data[w*32+b*8 +: 8] = w_nxt_keep[w*4+b] ? w_word[b*8 +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_ready <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_pkt_cnt   <= '0;
    end else begin
      r_cmd_ready <= (w_state_nxt == IDLE);
      r_cmd_err   <= w_accept && (cmd_len == '0);
      if (w_load) begin
        r_tvalid <= 1'b1;
        r_tlast  <= w_nxt_last;
      end else if (w_done) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
      if (w_done) r_pkt_cnt <= r_pkt_cnt + 32'd1;
    end
  end

  // payload flops need no reset: they only matter while m_tvalid is high
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_tdata <= w_nxt_data;
      r_tkeep <= w_nxt_keep;
      r_base  <= w_nxt_base;
      r_beat  <= w_nxt_beat;
    end
    if (w_first) begin
      r_tid      <= cmd_tid;
      r_tdest    <= cmd_tdest;
      r_last_idx <= w_cmd_last_idx;
      r_rem      <= w_cmd_rem;
    end
  end

`ifdef OFS_FIM_AXIS_PKT_TX_SOP_EN
  logic r_sop;
  always_ff @(posedge clk) begin
    if (w_load) r_sop <= w_first;
  end
  assign m_tuser = TUSER_WIDTH'(r_sop);
`else
  assign m_tuser = '0;
`endif

  assign cmd_ready = r_cmd_ready;
  assign cmd_err   = r_cmd_err;
  assign m_tvalid  = r_tvalid;
  assign m_tdata   = r_tdata;
  assign m_tkeep   = r_tkeep;
  assign m_tlast   = r_tlast;
  assign m_tid     = r_tid;
  assign m_tdest   = r_tdest;
  assign pkt_cnt   = r_pkt_cnt;

endmodule
